// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port (CPU / loader) memory arbiter.
package mem_arb_pkg;

    localparam int ARB_ADDR_W = 8;
    localparam int ARB_DATA_W = 8;
    localparam int LOCK_CNT_W = 5;

    // State names the owner of the most recent grant; IDLE counts as B.
    typedef enum logic [1:0] {
        IDLE,
        OWN_A,
        OWN_B,
        LOCK_B
    } arb_state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_t;

    // Command fields use the package widths; override ADDR_W/DATA_W together with these.
    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        port_id_t              port;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_rr2.sv
// Two-way round-robin winner select with a B-priority override for locked bursts.
module arb_rr2 (
    input  logic       a_req,
    input  logic       b_req,
    input  logic       last_b,
    input  logic       force_b,
    output logic [1:0] gnt
);

    logic b_wins;

    // B wins when forced, when alone, or when A was granted last.
    always_comb begin
        b_wins = b_req & (force_b | ~a_req | ~last_b);
        gnt    = {b_wins, a_req & ~b_wins};
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: round-robin A/B with B burst lock, two-stage command pipeline.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ARB_ADDR_W,
    parameter int DATA_W   = ARB_DATA_W,
    parameter int LOCK_MAX = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_a_req,
    input  logic              i_a_we,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_wdata,
    input  logic              i_b_req,
    input  logic              i_b_we,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_wdata,
    input  logic              i_b_lock,
    output logic              o_a_gnt,
    output logic              o_b_gnt,
    output logic              o_a_rvalid,
    output logic              o_b_rvalid,
    output logic [DATA_W-1:0] o_a_rdata,
    output logic [DATA_W-1:0] o_b_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_data_write,
    output logic              o_mem_write_enable,
    input  logic [DATA_W-1:0] i_mem_data_read
);

    localparam logic [LOCK_CNT_W:0] LOCK_LIM = LOCK_MAX[LOCK_CNT_W:0];

    arb_state_t            state, state_nxt;
    logic [LOCK_CNT_W-1:0] lock_cnt, lock_cnt_nxt;
    logic [LOCK_CNT_W:0]   lock_cnt_inc;
    logic [1:0]            gnt_p0;
    logic                  last_b, force_b;
    mem_cmd_t              cmd_p0, cmd_p1;
    logic                  vld_p1;
    logic                  rd_a_p1, rd_b_p1;
    logic                  a_rvalid_p2, b_rvalid_p2;
    logic [DATA_W-1:0]     a_rdata_p2, b_rdata_p2;

    assign last_b  = (state != OWN_A);
    assign force_b = (state == LOCK_B) & i_b_lock;

    arb_rr2 u_rr (
        .a_req   (i_a_req & ~i_rst),
        .b_req   (i_b_req & ~i_rst),
        .last_b  (last_b),
        .force_b (force_b),
        .gnt     (gnt_p0)
    );

    assign o_a_gnt = gnt_p0[0];
    assign o_b_gnt = gnt_p0[1];

    // The lock counter only advances on B grants that keep A waiting.
    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        lock_cnt_inc = {1'b0, lock_cnt} + {{LOCK_CNT_W{1'b0}}, i_a_req};
        if (gnt_p0[0]) begin
            state_nxt    = OWN_A;
            lock_cnt_nxt = '0;
        end else if (gnt_p0[1]) begin
            if (i_b_lock && (lock_cnt_inc < LOCK_LIM)) begin
                state_nxt    = LOCK_B;
                lock_cnt_nxt = lock_cnt_inc[LOCK_CNT_W-1:0];
            end else begin
                state_nxt    = OWN_B;
                lock_cnt_nxt = '0;
            end
        end else if ((state == LOCK_B) && !i_b_lock) begin
            state_nxt    = OWN_B;
            lock_cnt_nxt = '0;
        end
    end

    always_comb begin
        cmd_p0.we    = gnt_p0[1] ? i_b_we : i_a_we;
        cmd_p0.addr  = ARB_ADDR_W'(gnt_p0[1] ? i_b_addr : i_a_addr);
        cmd_p0.wdata = ARB_DATA_W'(gnt_p0[1] ? i_b_wdata : i_a_wdata);
        cmd_p0.port  = gnt_p0[1] ? PORT_B : PORT_A;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    // Stage 1: accepted command; the register holds its last value when idle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_p1 <= 1'b0;
            cmd_p1 <= '0;
        end else begin
            vld_p1 <= |gnt_p0;
            if (|gnt_p0) begin
                cmd_p1 <= cmd_p0;
            end
        end
    end

    assign o_mem_addr         = ADDR_W'(cmd_p1.addr);
    assign o_mem_data_write   = DATA_W'(cmd_p1.wdata);
    assign o_mem_write_enable = vld_p1 & cmd_p1.we;

    assign rd_a_p1 = vld_p1 & ~cmd_p1.we & (cmd_p1.port == PORT_A);
    assign rd_b_p1 = vld_p1 & ~cmd_p1.we & (cmd_p1.port == PORT_B);

    // Stage 2: memory access; asynchronous read data is captured at its end.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_rvalid_p2 <= 1'b0;
            b_rvalid_p2 <= 1'b0;
            a_rdata_p2  <= '0;
            b_rdata_p2  <= '0;
        end else begin
            a_rvalid_p2 <= rd_a_p1;
            b_rvalid_p2 <= rd_b_p1;
            if (rd_a_p1) begin
                a_rdata_p2 <= i_mem_data_read;
            end
            if (rd_b_p1) begin
                b_rdata_p2 <= i_mem_data_read;
            end
        end
    end

    assign o_a_rvalid = a_rvalid_p2;
    assign o_b_rvalid = b_rvalid_p2;
    assign o_a_rdata  = a_rdata_p2;
    assign o_b_rdata  = b_rdata_p2;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_arbiter;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int LOCK_MAX = 16;
    localparam int HMAX     = 1024;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_a_req = 1'b0, i_a_we = 1'b0;
    logic              i_b_req = 1'b0, i_b_we = 1'b0, i_b_lock = 1'b0;
    logic [ADDR_W-1:0] i_a_addr = '0, i_b_addr = '0;
    logic [DATA_W-1:0] i_a_wdata = '0, i_b_wdata = '0;
    logic              o_a_gnt, o_b_gnt, o_a_rvalid, o_b_rvalid;
    logic [DATA_W-1:0] o_a_rdata, o_b_rdata, o_mem_data_write, i_mem_data_read;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_write_enable;

    logic [DATA_W-1:0] mem [256];
    logic              init_mem = 1'b0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_a_req(i_a_req), .i_a_we(i_a_we), .i_a_addr(i_a_addr), .i_a_wdata(i_a_wdata),
        .i_b_req(i_b_req), .i_b_we(i_b_we), .i_b_addr(i_b_addr), .i_b_wdata(i_b_wdata),
        .i_b_lock(i_b_lock),
        .o_a_gnt(o_a_gnt), .o_b_gnt(o_b_gnt),
        .o_a_rvalid(o_a_rvalid), .o_b_rvalid(o_b_rvalid),
        .o_a_rdata(o_a_rdata), .o_b_rdata(o_b_rdata),
        .o_mem_addr(o_mem_addr), .o_mem_data_write(o_mem_data_write),
        .o_mem_write_enable(o_mem_write_enable), .i_mem_data_read(i_mem_data_read)
    );

    initial forever #5 i_clk = ~i_clk;

    function automatic logic [DATA_W-1:0] mem_init(input int i);
        return (i == 0) ? 8'h19 : 8'(i * 37 + 5);
    endfunction

    // Synchronous-write, asynchronous-read memory; contents are not touched by i_rst.
    always @(posedge i_clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= mem_init(i);
        end else if (o_mem_write_enable) begin
            mem[o_mem_addr] <= o_mem_data_write;
        end
    end
    assign i_mem_data_read = mem[o_mem_addr];

    int errors = 0;
    int checks = 0;

    // Reference model: in-order access history, shadow memory, fairness/lock bookkeeping.
    logic [DATA_W-1:0] shadow [256];
    bit                h_vld [HMAX];
    bit                h_port[HMAX];
    bit                h_we  [HMAX];
    logic [ADDR_W-1:0] h_addr [HMAX];
    logic [DATA_W-1:0] h_wdata[HMAX];
    logic [DATA_W-1:0] h_rdata[HMAX];
    bit                m_last_b;
    bit                m_lock;
    int                m_wait;
    logic [DATA_W-1:0] exp_ra, exp_rb;
    int                cyc = 0;
    logic              d_a, d_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < HMAX; i++) h_vld[i] = 1'b0;
        m_last_b = 1'b1;
        m_lock   = 1'b0;
        m_wait   = 0;
        exp_ra   = '0;
        exp_rb   = '0;
    endtask

    task automatic peek();
        #3;
    endtask

    // One clock cycle: compare all outputs at the falling edge, then record acceptance.
    task automatic tick();
        logic              ea, eb;
        int                c, p1, p2;
        logic [ADDR_W-1:0] ad;
        @(negedge i_clk);
        c  = cyc % HMAX;
        p1 = (cyc + HMAX - 1) % HMAX;
        p2 = (cyc + HMAX - 2) % HMAX;
        ea = 1'b0;
        eb = 1'b0;
        if (i_b_req && m_lock && i_b_lock) eb = 1'b1;
        else if (i_a_req && i_b_req) begin
            if (m_last_b) ea = 1'b1; else eb = 1'b1;
        end
        else if (i_a_req) ea = 1'b1;
        else if (i_b_req) eb = 1'b1;
        d_a = o_a_gnt;
        d_b = o_b_gnt;
        chk("a_gnt", o_a_gnt, ea);
        chk("b_gnt", o_b_gnt, eb);
        chk("mem_we", o_mem_write_enable, h_vld[p1] && h_we[p1]);
        if (h_vld[p1] && h_we[p1]) begin
            chk("mem_addr", o_mem_addr, h_addr[p1]);
            chk("mem_wdata", o_mem_data_write, h_wdata[p1]);
        end
        if (h_vld[p2] && !h_we[p2]) begin
            if (h_port[p2]) exp_rb = h_rdata[p2];
            else            exp_ra = h_rdata[p2];
        end
        chk("a_rvalid", o_a_rvalid, h_vld[p2] && !h_we[p2] && !h_port[p2]);
        chk("b_rvalid", o_b_rvalid, h_vld[p2] && !h_we[p2] && h_port[p2]);
        chk("a_rdata", o_a_rdata, exp_ra);
        chk("b_rdata", o_b_rdata, exp_rb);
        h_vld[c] = ea | eb;
        if (ea | eb) begin
            h_port[c]  = eb;
            h_we[c]    = eb ? i_b_we : i_a_we;
            ad         = eb ? i_b_addr : i_a_addr;
            h_addr[c]  = ad;
            h_wdata[c] = eb ? i_b_wdata : i_a_wdata;
            h_rdata[c] = shadow[ad];
            if (h_we[c]) shadow[ad] = h_wdata[c];
        end
        if (ea) begin
            m_last_b = 1'b0; m_lock = 1'b0; m_wait = 0;
        end else if (eb) begin
            m_last_b = 1'b1;
            if (i_b_lock) begin
                m_lock = 1'b1;
                if (i_a_req) m_wait++;
                if (m_wait >= LOCK_MAX) begin m_lock = 1'b0; m_wait = 0; end
            end else begin
                m_lock = 1'b0; m_wait = 0;
            end
        end else if (!i_b_lock) begin
            m_lock = 1'b0; m_wait = 0;
        end
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        i_a_req  = 1'b0;
        i_b_req  = 1'b0;
        i_b_lock = 1'b0;
        i_rst    = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            chk("rst_outs", {o_a_gnt, o_b_gnt, o_a_rvalid, o_b_rvalid, o_a_rdata, o_b_rdata,
                             o_mem_addr, o_mem_data_write, o_mem_write_enable}, 64'd0);
            @(posedge i_clk);
            #1;
        end
        i_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int nb;
        init_mem = 1'b1;
        @(posedge i_clk);
        #1;
        init_mem = 1'b0;
        for (int i = 0; i < 256; i++) shadow[i] = mem_init(i);
        do_reset(2);

        // A reads 0x00 right after reset
        i_a_req = 1'b1; i_a_we = 1'b0; i_a_addr = 8'h00;
        tick();
        i_a_req = 1'b0;
        tick();
        peek();
        chk("first_rvalid", o_a_rvalid, 1'b1);
        chk("first_rdata", o_a_rdata, 8'h19);
        tick();
        tick();

        // Both ports read continuously: strict alternation starting with A
        do_reset(1);
        i_a_req = 1'b1; i_a_we = 1'b0; i_a_addr = 8'h01;
        i_b_req = 1'b1; i_b_we = 1'b0; i_b_addr = 8'h02;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rr_seq_a", d_a, (i % 2) == 0);
            chk("rr_seq_b", d_b, (i % 2) == 1);
        end
        i_a_req = 1'b0; i_b_req = 1'b0;
        tick(); tick(); tick();
        peek();
        chk("rr_a_data", o_a_rdata, mem_init(1));
        chk("rr_b_data", o_b_rdata, mem_init(2));

        // B writes 0x14, A reads it the next cycle
        i_b_req = 1'b1; i_b_we = 1'b1; i_b_addr = 8'h14; i_b_wdata = 8'hAA;
        tick();
        i_b_req = 1'b0;
        i_a_req = 1'b1; i_a_we = 1'b0; i_a_addr = 8'h14;
        tick();
        i_a_req = 1'b0;
        tick();
        peek();
        chk("wr_rd_rvalid", o_a_rvalid, 1'b1);
        chk("wr_rd_data", o_a_rdata, 8'hAA);
        tick();

        // B locked burst with A write waiting throughout
        i_a_req = 1'b1; i_a_we = 1'b1; i_a_addr = 8'h30; i_a_wdata = 8'h55;
        i_b_req = 1'b1; i_b_we = 1'b0; i_b_lock = 1'b1; i_b_addr = 8'h40;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (d_a) break;
            if (d_b) begin
                nb++;
                i_b_addr = 8'h40 + 8'($urandom_range(0, 15));
            end
        end
        chk("lock_a_granted", d_a, 1'b1);
        chk("lock_b_grants", nb, LOCK_MAX);
        i_a_req = 1'b0; i_b_req = 1'b0; i_b_lock = 1'b0;
        chk("a_wr_held", mem[8'h30], mem_init(8'h30));
        tick();
        chk("a_wr_done", mem[8'h30], 8'h55);
        tick();

        // Reset in the cycle after an A read is accepted
        i_a_req = 1'b1; i_a_we = 1'b0; i_a_addr = 8'h00;
        tick();
        do_reset(2);
        peek();
        chk("mem_keep_00", mem[8'h00], 8'h19);
        chk("mem_keep_14", mem[8'h14], 8'hAA);
        chk("mem_keep_30", mem[8'h30], 8'h55);
        tick();
        tick();

        // Randomized traffic; requests hold until granted
        for (int n = 0; n < 400; n++) begin
            if (!i_a_req) begin
                i_a_req   = ($urandom_range(0, 2) != 0);
                i_a_we    = 1'($urandom_range(0, 1));
                i_a_addr  = 8'($urandom_range(0, 7));
                i_a_wdata = 8'($urandom);
            end
            if (!i_b_req) begin
                i_b_req   = ($urandom_range(0, 2) != 0);
                i_b_we    = 1'($urandom_range(0, 1));
                i_b_addr  = 8'($urandom_range(0, 7));
                i_b_wdata = 8'($urandom);
                i_b_lock  = ($urandom_range(0, 3) == 0);
            end
            tick();
            if (d_a) i_a_req = 1'b0;
            if (d_b) i_b_req = 1'b0;
        end
        i_a_req = 1'b0; i_b_req = 1'b0; i_b_lock = 1'b0;
        tick(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the memory data width.
REQ-003 The block SHALL have parameter LOCK_MAX, default 16, meaning the maximum number of consecutive locked B grants while A waits.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, with ports as listed below.
REQ-005 i_clk  in  1  clock, all state on rising edge.
REQ-006 i_rst  in  1  asynchronous active-high reset.
REQ-007 i_a_req / i_b_req  in  1  requester A (CPU) / B (loader) access request.
REQ-008 i_a_we / i_b_we  in  1  request is a write.
REQ-009 i_a_addr / i_b_addr  in  ADDR_W  request address.
REQ-010 i_a_wdata / i_b_wdata  in  DATA_W  write data.
REQ-011 i_b_lock  in  1  B asks to keep ownership for a burst.
REQ-012 o_a_gnt / o_b_gnt  out  1  request accepted this cycle.
REQ-013 o_a_rvalid / o_b_rvalid  out  1  o_x_rdata valid, one-cycle pulse.
REQ-014 o_a_rdata / o_b_rdata  out  DATA_W  registered read data.
REQ-015 o_mem_addr  out  ADDR_W  memory address.
REQ-016 o_mem_data_write  out  DATA_W  memory write data.
REQ-017 o_mem_write_enable  out  1  memory write strobe.
REQ-018 i_mem_data_read  in  DATA_W  asynchronous memory read data.

Function
REQ-019 A request SHALL be accepted in the cycle o_x_gnt=1 with i_x_req=1; the requester SHALL hold all request inputs stable until then.
REQ-020 o_a_gnt and o_b_gnt SHALL be combinational from the requests and the arbiter state, mutually exclusive, and at most one per cycle.
REQ-021 Arbitration SHALL be round-robin: with both requesting, the winner is the port not granted last; last-granted resets to B, so A wins first.
REQ-022 Accepted commands SHALL be registered (stage 1), then o_mem_* SHALL be driven from that register in the next cycle (stage 2); otherwise o_mem_write_enable=0 and the address/data hold.
REQ-023 For a read, i_mem_data_read SHALL be captured at the end of stage 2, so o_x_rvalid is high exactly 2 cycles after acceptance with o_x_rdata valid; o_x_rdata holds until the next read.
REQ-024 Writes SHALL produce no rvalid.
REQ-025 Back-to-back acceptance SHALL be supported: one access per cycle, in order.
REQ-026 A write followed next cycle by a read of the same address SHALL return the new data.
REQ-027 The arbiter SHALL have states IDLE, OWN_A, OWN_B and LOCK_B, naming the owner of the last grant.
REQ-028 LOCK_B SHALL be entered on a B grant with i_b_lock=1. B then wins regardless of A, and a 5-bit lock counter increments on each locked grant while i_a_req=1.
REQ-029 LOCK_B SHALL exit to round-robin when i_b_lock=0 or the counter reaches LOCK_MAX. On a LOCK_MAX exit A receives the next grant, and the counter clears on exit.
REQ-030 With no requests the arbiter SHALL stay in its state, and no o_x_gnt SHALL be asserted.

Reset
REQ-031 On reset, all outputs SHALL be 0, the state SHALL be IDLE, the pipeline valid bits and lock counter SHALL be cleared, and last-granted SHALL be B.
REQ-032 Reset mid-operation SHALL discard in-flight commands, with no rvalid and no memory write after reset.
REQ-033 Memory contents SHALL be unaffected by reset.

Structure
REQ-034 Package mem_arb_pkg SHALL hold the state enum, the port-id enum {PORT_A, PORT_B}, the command struct (we, addr, wdata, port) and default widths.
REQ-035 Winner selection SHALL be one sub-module, arb_rr2: two requests, last-granted and force_b in; one-hot grant out.

Verification
REQ-036 A reads 0x00 after reset with the memory preloaded with 0x19 -> o_a_gnt in cycle 0, o_a_rvalid in cycle 2 with o_a_rdata=0x19.
REQ-037 A and B request reads of 0x01 and 0x02 every cycle -> grants alternate A,B,A,B, and each rvalid matches its own port's data.
REQ-038 B writes 0xAA to 0x14, then A reads 0x14 next cycle -> o_a_rdata=0xAA.
REQ-039 B holds i_b_lock=1 with continuous requests and A requests throughout -> B gets exactly 16 grants, then A is granted.
REQ-040 i_rst asserted in the cycle after an A read is accepted -> no o_a_rvalid, all outputs 0, and the memory is unchanged.
REQ-041 A write request is held with o_a_gnt=0 while B is locked -> o_mem_write_enable never asserts for A until o_a_gnt.
